// File: rtl/nla_fifo_scheduler.sv
// Schedules the shared sync FIFO: round-robin producer writes, reads drained into a
// 2-entry output buffer, with write and read slots strictly alternating under contention.
module nla_fifo_scheduler #(
    parameter int unsigned          DATA_W  = 32,
    parameter int unsigned          N_REQ   = 4,
    parameter logic [DATA_W-1:0]    START_W = 32'h7F90_0000
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic                    fifo_wr_en_o,
    output logic [DATA_W-1:0]       fifo_wdata_o,
    output logic                    fifo_rd_en_o,
    input  logic [DATA_W-1:0]       fifo_rdata_i,
    input  logic                    fifo_full_i,
    input  logic                    fifo_empty_i,
    output logic                    out_valid_o,
    output logic [DATA_W-1:0]       out_data_o,
    input  logic                    out_ready_i,
    output logic                    frame_start_o
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    typedef enum logic {StWrTurn, StRdTurn} mode_e;

    mode_e              mode_q, mode_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               in_flight_q;
    logic               frame_start_q, frame_start_d;
    logic [DATA_W-1:0]  buf_q [2];
    logic               buf_wr_ptr_q, buf_rd_ptr_q;
    logic [1:0]         buf_cnt_q;

    logic [N_REQ-1:0]   is_start;
    logic [N_REQ-1:0]   req_elig;
    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   scan_idx;
    logic [DATA_W-1:0]  grant_data;
    logic               wr_elig, rd_elig;
    logic               wr_slot, rd_slot;
    logic               buf_push, buf_pop;

    // Frame-start markers bypass the full flag because they never reach the FIFO.
    always_comb begin
        is_start = '0;
        req_elig = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            is_start[i] = (req_data_i[i*DATA_W +: DATA_W] == START_W);
            req_elig[i] = req_valid_i[i] && (!fifo_full_i || is_start[i]);
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = IDX_W'((32'(rr_ptr_q) + k) % N_REQ);
            if (!grant_found && req_elig[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign grant_data = req_data_i[grant_idx*DATA_W +: DATA_W];
    assign wr_elig    = |req_elig;
    // Reserve buffer space for the word still in flight from the FIFO.
    assign rd_elig    = !fifo_empty_i && ((buf_cnt_q + {1'b0, in_flight_q}) < 2'd2);

    // Mode state register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            mode_q <= StWrTurn;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode next state: flips only on contested slots.
    always_comb begin
        mode_d = mode_q;
        if (wr_elig && rd_elig) begin
            mode_d = (mode_q == StWrTurn) ? StRdTurn : StWrTurn;
        end
    end

    // Slot decision and port outputs.
    always_comb begin
        wr_slot       = 1'b0;
        rd_slot       = 1'b0;
        req_ready_o   = '0;
        fifo_wr_en_o  = 1'b0;
        fifo_wdata_o  = '0;
        fifo_rd_en_o  = 1'b0;
        frame_start_d = 1'b0;
        rr_ptr_d      = rr_ptr_q;
        if (rstn_i) begin
            if (wr_elig && rd_elig) begin
                wr_slot = (mode_q == StWrTurn);
                rd_slot = (mode_q == StRdTurn);
            end else begin
                wr_slot = wr_elig;
                rd_slot = rd_elig;
            end
        end
        if (wr_slot && grant_found) begin
            req_ready_o[grant_idx] = 1'b1;
            rr_ptr_d = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            if (is_start[grant_idx]) begin
                frame_start_d = 1'b1;
            end else begin
                fifo_wr_en_o = 1'b1;
                fifo_wdata_o = grant_data;
            end
        end
        fifo_rd_en_o = rd_slot;
    end

    assign buf_push      = in_flight_q;
    assign out_valid_o   = (buf_cnt_q != 2'd0);
    assign buf_pop       = out_valid_o && out_ready_i;
    assign out_data_o    = out_valid_o ? buf_q[buf_rd_ptr_q] : '0;
    assign frame_start_o = frame_start_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rr_ptr_q      <= '0;
            in_flight_q   <= 1'b0;
            frame_start_q <= 1'b0;
            buf_wr_ptr_q  <= 1'b0;
            buf_rd_ptr_q  <= 1'b0;
            buf_cnt_q     <= 2'd0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            in_flight_q   <= fifo_rd_en_o;
            frame_start_q <= frame_start_d;
            if (buf_push) begin
                buf_wr_ptr_q <= ~buf_wr_ptr_q;
            end
            if (buf_pop) begin
                buf_rd_ptr_q <= ~buf_rd_ptr_q;
            end
            buf_cnt_q <= buf_cnt_q + 2'(buf_push) - 2'(buf_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rstn_i && buf_push) begin
            buf_q[buf_wr_ptr_q] <= fifo_rdata_i;
        end
    end

endmodule
